lsu_port: RTL and testbench

LSU_PORT -- requirements
Module: lsu_port

---
 rtl/lsu_port.sv | 139 +++++++++++++
 tb/tb_lsu_port.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/lsu_port.sv
// RV32I load/store unit port: one access in flight, byte/half stores done as read-merge-write.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
module lsu_port #(
   parameter int unsigned MEM_BYTES = 65536
) (
   input  logic        m_clock,
   input  logic        p_reset,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        fault,
   output logic        busy,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_t;

   state_t      state_reg, state_next;
   logic        we_reg;
   logic [2:0]  funct3_reg;
   logic [31:0] addr_reg, wdata_reg, captured_reg, rdata_reg;
   logic        fault_reg;

   logic [32:0] size_ext;
   logic        funct3_bad, range_bad, misalign_bad, access_fault;
   logic        is_word_store, mem_we_raw;

   always_comb begin
      case (funct3_reg[1:0])
         2'd0:    size_ext = 33'd1;
         2'd1:    size_ext = 33'd2;
         default: size_ext = 33'd4;
      endcase
   end

   // Stores have no unsigned forms, so funct3 4/5 are illegal for them.
   assign funct3_bad = (funct3_reg[1:0] == 2'd3) || (funct3_reg[2] && funct3_reg[1])
                       || (we_reg && funct3_reg[2]);
   // 33-bit sum so addresses near 2^32 cannot wrap past the bound.
   assign range_bad  = ({1'b0, addr_reg} + size_ext) > 33'(MEM_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign_bad = (funct3_reg[1:0] == 2'd1 && addr_reg[0])
                         || (funct3_reg[1:0] == 2'd2 && addr_reg[1:0] != 2'd0);
`else
   assign misalign_bad = 1'b0;
`endif
   assign access_fault  = funct3_bad || range_bad || misalign_bad;
   assign is_word_store = we_reg && (funct3_reg[1:0] == 2'd2);

   function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
      case (f3)
         3'd0:    extend_load = {{24{raw[7]}}, raw[7:0]};
         3'd1:    extend_load = {{16{raw[15]}}, raw[15:0]};
         3'd4:    extend_load = {24'd0, raw[7:0]};
         3'd5:    extend_load = {16'd0, raw[15:0]};
         default: extend_load = raw;
      endcase
   endfunction

   always_ff @(posedge m_clock) begin
      if (p_reset) state_reg <= IDLE;
      else         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req) state_next = ACCESS;
         ACCESS:  state_next = (access_fault || !we_reg || is_word_store) ? DONE : MERGE;
         MERGE:   state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         we_reg       <= 1'b0;
         funct3_reg   <= 3'd0;
         addr_reg     <= 32'd0;
         wdata_reg    <= 32'd0;
         captured_reg <= 32'd0;
         rdata_reg    <= 32'd0;
         fault_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: if (req) begin
               we_reg       <= we;
               funct3_reg   <= funct3;
               addr_reg     <= addr;
               wdata_reg    <= wdata;
               captured_reg <= 32'd0;
               rdata_reg    <= 32'd0;
               fault_reg    <= 1'b0;
            end
            ACCESS: begin
               fault_reg <= access_fault;
               if (!access_fault) begin
                  if (!we_reg) rdata_reg    <= extend_load(funct3_reg, mem_rdata);
                  else         captured_reg <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy       = (state_reg != IDLE);
      ack        = (state_reg == DONE);
      rdata      = (state_reg == DONE) ? rdata_reg : 32'd0;
      fault      = (state_reg == DONE) && fault_reg;
      mem_addr   = busy ? addr_reg : 32'd0;
      mem_wdata  = 32'd0;
      mem_we_raw = 1'b0;
      case (state_reg)
         ACCESS: if (is_word_store && !access_fault) begin
            mem_we_raw = 1'b1;
            mem_wdata  = wdata_reg;
         end
         MERGE: begin
            mem_we_raw = 1'b1;
            mem_wdata  = funct3_reg[0] ? {captured_reg[31:16], wdata_reg[15:0]}
                                       : {captured_reg[31:8],  wdata_reg[7:0]};
         end
         default: ;
      endcase
   end

   // Reset must block the write on the very edge it is sampled.
   assign mem_we = mem_we_raw && !p_reset;

endmodule

// File: tb/tb_lsu_port.sv
// Directed bench for lsu_port with a 64 KiB byte-addressed RAM model.
// Expectations for misaligned LW follow LSU_MISALIGN_TRAP_EN.
module tb_lsu_port;
   localparam int unsigned MEM_BYTES = 65536;

   logic        clk = 1'b0;
   logic        p_reset, req, we;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        ack, fault, busy, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

   logic [7:0]  mem [MEM_BYTES];
   logic [15:0] ra;
   int          we_cnt = 0;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   lsu_port #(.MEM_BYTES(MEM_BYTES)) dut (
      .m_clock(clk), .p_reset(p_reset), .req(req), .we(we), .funct3(funct3),
      .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .fault(fault),
      .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   assign ra        = mem_addr[15:0];
   assign mem_rdata = {mem[ra + 16'd3], mem[ra + 16'd2], mem[ra + 16'd1], mem[ra]};

   always @(posedge clk) begin
      if (mem_we) begin
         mem[ra]          <= mem_wdata[7:0];
         mem[ra + 16'd1]  <= mem_wdata[15:8];
         mem[ra + 16'd2]  <= mem_wdata[23:16];
         mem[ra + 16'd3]  <= mem_wdata[31:24];
         we_cnt           <= we_cnt + 1;
      end
   end

   function automatic logic [31:0] word_at(input logic [15:0] a);
      word_at = {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]};
   endfunction

   task automatic put_word(input logic [15:0] a, input logic [31:0] v);
      mem[a]         = v[7:0];
      mem[a + 16'd1] = v[15:8];
      mem[a + 16'd2] = v[23:16];
      mem[a + 16'd3] = v[31:24];
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete transaction: latency in cycles from the request cycle to ack.
   task automatic access(input string tag, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                         input logic [31:0] exp_rd, input logic exp_f);
      int cyc;
      int w0;
      @(negedge clk);
      w0 = we_cnt;
      req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0;
      cyc = 1;
      while (!ack && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
      chk({tag, " rdata"}, rdata, exp_rd);
      chk({tag, " fault"}, {31'd0, fault}, {31'd0, exp_f});
      @(negedge clk);
      chk({tag, " ack one cycle"}, {31'd0, ack}, 32'd0);
      chk({tag, " mem_we cycles"}, 32'(we_cnt - w0), (w && !exp_f) ? 32'd1 : 32'd0);
   endtask

   initial begin
      int w0;
      int acks;
      for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'h00;
      put_word(16'h0100, 32'h1234_5678);
      mem[16'h0104] = 8'h9A;
      p_reset = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset ack", {31'd0, ack}, 32'd0);
      chk("reset rdata", rdata, 32'd0);
      chk("reset mem_we", {31'd0, mem_we}, 32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      p_reset = 1'b0;

      access("LW 100", 1'b0, 3'd2, 32'h100, 32'd0, 2, 32'h1234_5678, 1'b0);
      access("SB 100", 1'b1, 3'd0, 32'h100, 32'h0000_00AB, 3, 32'd0, 1'b0);
      chk("SB word", word_at(16'h0100), 32'h1234_56AB);
      access("LB 100", 1'b0, 3'd0, 32'h100, 32'd0, 2, 32'hFFFF_FFAB, 1'b0);
      access("LBU 100", 1'b0, 3'd4, 32'h100, 32'd0, 2, 32'h0000_00AB, 1'b0);

      put_word(16'h0100, 32'h1234_5678);
      access("SH 102", 1'b1, 3'd1, 32'h102, 32'h0000_BEEF, 3, 32'd0, 1'b0);
      chk("SH word", word_at(16'h0100), 32'hBEEF_5678);
      access("LH 102", 1'b0, 3'd1, 32'h102, 32'd0, 2, 32'hFFFF_BEEF, 1'b0);
      access("LHU 102", 1'b0, 3'd5, 32'h102, 32'd0, 2, 32'h0000_BEEF, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
      access("LW 101", 1'b0, 3'd2, 32'h101, 32'd0, 2, 32'd0, 1'b1);
`else
      access("LW 101", 1'b0, 3'd2, 32'h101, 32'd0, 2, 32'h9ABE_EF56, 1'b0);
`endif

      access("SW top-3", 1'b1, 3'd2, MEM_BYTES - 3, 32'hDEAD_BEEF, 2, 32'd0, 1'b1);
      chk("SW top-3 mem", word_at(16'hFFFC), 32'd0);
      access("SW f3=3", 1'b1, 3'd3, 32'h100, 32'hDEAD_BEEF, 2, 32'd0, 1'b1);
      chk("SW f3=3 mem", word_at(16'h0100), 32'hBEEF_5678);
      access("SW top-4", 1'b1, 3'd2, MEM_BYTES - 4, 32'hCAFE_F00D, 2, 32'd0, 1'b0);
      chk("SW top-4 mem", word_at(16'hFFFC), 32'hCAFE_F00D);
      access("LB top-1", 1'b0, 3'd0, MEM_BYTES - 1, 32'd0, 2, 32'hFFFF_FFCA, 1'b0);
      access("LH top-1", 1'b0, 3'd1, MEM_BYTES - 1, 32'd0, 2, 32'd0, 1'b1);

      // Reset lands while the SH is in MERGE: no write, word intact.
      put_word(16'h0200, 32'h1122_3344);
      @(negedge clk);
      w0 = we_cnt;
      req = 1'b1; we = 1'b1; funct3 = 3'd1; addr = 32'h200; wdata = 32'h0000_BEEF;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      chk("SH merge busy", {31'd0, busy}, 32'd1);
      chk("SH merge mem_we", {31'd0, mem_we}, 32'd1);
      p_reset = 1'b1;
      @(negedge clk);
      p_reset = 1'b0;
      chk("rst merge busy", {31'd0, busy}, 32'd0);
      chk("rst merge no write", 32'(we_cnt - w0), 32'd0);
      chk("rst merge word", word_at(16'h0200), 32'h1122_3344);

      // Request presented together with reset is dropped.
      @(negedge clk);
      p_reset = 1'b1; req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h100;
      @(negedge clk);
      p_reset = 1'b0; req = 1'b0;
      chk("req in reset dropped", {31'd0, busy}, 32'd0);

      // Second request while busy is ignored: exactly one ack.
      @(negedge clk);
      req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h100;
      @(negedge clk);
      addr = 32'h200;
      @(negedge clk);
      chk("busy req ack", {31'd0, ack}, 32'd1);
      chk("busy req rdata", rdata, 32'hBEEF_5678);
      req = 1'b0;
      acks = 0;
      repeat (5) begin
         @(negedge clk);
         acks += int'(ack);
      end
      chk("busy req single ack", 32'(acks), 32'd0);
      chk("busy req idle", {31'd0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
